// File: rtl/img_buf_rd_stream_if.sv
// ---------------------------------------------------------------------------
// img_buf_rd_stream_if
//   Valid/ready chunk stream that leaves the image-buffer row reader.
//
//   Signals:
//     out_data  [OUT_W]  current chunk of the row being streamed
//     out_valid          chunk valid
//     out_ready          downstream accepts the chunk this cycle
//     out_sol            chunk is the first (LSB) chunk of a row
//     out_last           chunk is the final chunk of the final row of a frame
//
//   Modports:
//     master  the reader (drives data/valid/sol/last, samples ready)
//     slave   the consumer (coprocessor datapath or VGA/host path)
// ---------------------------------------------------------------------------
interface img_buf_rd_stream_if #(
  parameter int OUT_W = 32
);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sol;
  logic             out_last;

  modport master (
    output out_data, out_valid, out_sol, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_sol, out_last,
    output out_ready
  );
endinterface

// File: rtl/img_buf_rd_stream.sv
// ---------------------------------------------------------------------------
// img_buf_rd_stream
//   Row-streaming reader for the ROWS x ROW_W 1-bpp image buffer. A start
//   command selects a contiguous (possibly wrapping) range of rows. Each row
//   is fetched through the buffer's synchronous read port (one-cycle read
//   latency) and serialized LSB-first into OUT_W-bit chunks on a valid/ready
//   stream. Every row costs FETCH + LOAD + CHUNKS stream cycles.
//
//   Ports:
//     clk        system clock, posedge
//     rst_n      asynchronous active-low reset
//     start      command strobe, sampled only while idle
//     row_first  first row of the frame, captured with an accepted start
//     row_last   last row of the frame, captured with an accepted start
//     busy       high from the cycle after an accepted start through DONE
//     done       one-cycle pulse at the end of a frame
//     raddr      buffer read address (registered; equals the current row)
//     rdata      buffer read data, valid one clock after raddr
//     strm       chunk stream, img_buf_rd_stream_if.master
//
//   Configuration:
//     IMG_RD_VFLIP_EN  when defined, rows are walked downward (vertical flip)
//                      and the frame spans (row_first - row_last) mod ROWS + 1
//                      rows; otherwise rows are walked upward.
// ---------------------------------------------------------------------------
module img_buf_rd_stream #(
  parameter int ROWS   = 512,
  parameter int ROW_W  = 512,
  parameter int OUT_W  = 32,
  parameter int ADDR_W = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     row_first,
  input  logic [ADDR_W-1:0]     row_last,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     raddr,
  input  logic [ROW_W-1:0]      rdata,
  img_buf_rd_stream_if.master   strm
);

  localparam int CHUNKS = ROW_W / OUT_W;
  localparam int CIDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CIDX_W-1:0] CIDX_LAST = CIDX_W'(CHUNKS - 1);
  localparam logic [CIDX_W-1:0] CIDX_PEN  = CIDX_W'(CHUNKS - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_STREAM,
    S_DONE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cur_row;
  logic [ADDR_W-1:0]   rows_left;  // rows still to fetch after the current one
  logic [CIDX_W-1:0]   chunk_idx;
  logic [ROW_W-1:0]    row_reg;    // shifted right one chunk per handshake
  logic                out_valid_q;
  logic                out_sol_q;
  logic                out_last_q;

  // (a - b) mod ROWS for row indices in 0..ROWS-1.
  function automatic logic [ADDR_W-1:0] row_span(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
    if (a >= b) return a - b;
    return ADDR_W'(ROWS - int'(b) + int'(a));
  endfunction

  function automatic logic [ADDR_W-1:0] next_row(input logic [ADDR_W-1:0] r);
`ifdef IMG_RD_VFLIP_EN
    if (r == '0) return ADDR_W'(ROWS - 1);
    return r - 1'b1;
`else
    if (r == ADDR_W'(ROWS - 1)) return '0;
    return r + 1'b1;
`endif
  endfunction

  // The read address is the current-row register itself, so the buffer sees
  // the new row from the first FETCH cycle onward.
  assign raddr          = cur_row;
  assign strm.out_data  = row_reg[OUT_W-1:0];
  assign strm.out_valid = out_valid_q;
  assign strm.out_sol   = out_sol_q;
  assign strm.out_last  = out_last_q;

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other; blocking assignments would make the result
  // depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cur_row     <= '0;
      rows_left   <= '0;
      chunk_idx   <= '0;
      // NOTE: the wide row register is reset on purpose: it drives out_data
      // directly and out_data must read 0 out of reset.
      row_reg     <= '0;
      out_valid_q <= 1'b0;
      out_sol_q   <= 1'b0;
      out_last_q  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cur_row <= row_first;
`ifdef IMG_RD_VFLIP_EN
            rows_left <= row_span(row_first, row_last);
`else
            rows_left <= row_span(row_last, row_first);
`endif
            busy  <= 1'b1;
            state <= S_FETCH;
          end
        end

        // Buffer samples raddr at the edge that closes this cycle.
        S_FETCH: state <= S_LOAD;

        S_LOAD: begin
          row_reg     <= rdata;
          chunk_idx   <= '0;
          out_valid_q <= 1'b1;
          out_sol_q   <= 1'b1;
          out_last_q  <= (CHUNKS == 1) && (rows_left == '0);
          state       <= S_STREAM;
        end

        S_STREAM: begin
          // Outputs only move on a handshake, which holds them under stall.
          if (strm.out_ready) begin
            row_reg    <= row_reg >> OUT_W;
            chunk_idx  <= chunk_idx + 1'b1;
            out_sol_q  <= 1'b0;
            out_last_q <= (chunk_idx == CIDX_PEN) && (rows_left == '0);
            if (chunk_idx == CIDX_LAST) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              if (rows_left == '0) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                rows_left <= rows_left - 1'b1;
                cur_row   <= next_row(cur_row);
                state     <= S_FETCH;
              end
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_buf_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_img_buf_rd_stream
//   Self-checking bench for img_buf_rd_stream. A behavioural buffer with a
//   one-cycle synchronous read port holds a known pattern; a table of frames
//   (range, ready pattern, expected row count) is replayed and every chunk is
//   compared with the pattern, plus hand-written reset sequences.
//   Define IMG_RD_VFLIP_EN for both bench and RTL to exercise the flip build.
// ---------------------------------------------------------------------------
module tb_img_buf_rd_stream;

  localparam int ROWS   = 512;
  localparam int ROW_W  = 512;
  localparam int OUT_W  = 32;
  localparam int ADDR_W = 9;
  localparam int CHUNKS = ROW_W / OUT_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] row_first = '0;
  logic [ADDR_W-1:0] row_last = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] raddr;
  logic [ROW_W-1:0]  rdata;
  logic [ROW_W-1:0]  mem [ROWS];

  img_buf_rd_stream_if #(.OUT_W(OUT_W)) strm ();

  img_buf_rd_stream #(
    .ROWS(ROWS), .ROW_W(ROW_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .row_first (row_first),
    .row_last  (row_last),
    .busy      (busy),
    .done      (done),
    .raddr     (raddr),
    .rdata     (rdata),
    .strm      (strm)
  );

  always #5 clk = ~clk;

  // Synchronous read port: data for raddr appears one clock later.
  always @(posedge clk) rdata <= mem[raddr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Chunk k of row r. Row 5 carries A5A5_0000 + k; all others are unique.
  function automatic logic [31:0] pat(input int r, input int k);
    if (r == 5) return 32'hA5A5_0000 + 32'(k);
    return {8'h3C ^ 8'(r), 8'(r >> 8), 8'(k), 8'(r * 3 + k)};
  endfunction

  function automatic int exp_row(input int first, input int i);
`ifdef IMG_RD_VFLIP_EN
    return (first - i + 2 * ROWS) % ROWS;
`else
    return (first + i) % ROWS;
`endif
  endfunction

  typedef struct {
    int first;
    int last;
    int mode;        // 0: out_ready always high, 1: random 50% ready
    int n_rows;      // hand-computed rows in the frame
    bit busy_start;  // pulse start again while streaming row 0
  } vec_t;

  vec_t vecs [7];

  // Runs one frame: start accepted at cycle 0, cycles numbered from there.
  task automatic run_frame(input int vi, input vec_t v);
    int hs, done_cyc, first_valid, total, budget, r, k;
    logic held_v, held_sol, held_last;
    logic [31:0] held_d;
    total = v.n_rows * CHUNKS;
    budget = 40 * v.n_rows + 40;
    hs = 0; done_cyc = -1; first_valid = -1; held_v = 1'b0;
    held_d = '0; held_sol = 1'b0; held_last = 1'b0;
    start = 1'b1;
    row_first = ADDR_W'(v.first);
    row_last  = ADDR_W'(v.last);
    strm.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    row_first = ~ADDR_W'(v.first);   // later changes must not matter
    row_last  = ADDR_W'(v.first);
    for (int c = 1; c <= budget && done_cyc < 0; c++) begin
      strm.out_ready = (v.mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (v.busy_start && c == 10) begin
        start = 1'b1; row_first = 9'd400; row_last = 9'd400;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (c == 1) check($sformatf("v%0d busy after start", vi), 64'(busy), 64'(1));
      if (held_v) begin
        check($sformatf("v%0d stall valid hs%0d", vi, hs), 64'(strm.out_valid), 64'(1));
        check($sformatf("v%0d stall data hs%0d", vi, hs), 64'(strm.out_data), 64'(held_d));
        check($sformatf("v%0d stall sol hs%0d", vi, hs), 64'(strm.out_sol), 64'(held_sol));
        check($sformatf("v%0d stall last hs%0d", vi, hs), 64'(strm.out_last), 64'(held_last));
      end
      if (strm.out_valid && first_valid < 0) first_valid = c;
      if (strm.out_valid && strm.out_ready) begin
        if (hs < total) begin
          r = exp_row(v.first, hs / CHUNKS);
          k = hs % CHUNKS;
          check($sformatf("v%0d data hs%0d", vi, hs), 64'(strm.out_data), 64'(pat(r, k)));
          check($sformatf("v%0d sol hs%0d", vi, hs), 64'(strm.out_sol), 64'(k == 0));
          check($sformatf("v%0d last hs%0d", vi, hs), 64'(strm.out_last), 64'(hs == total - 1));
          check($sformatf("v%0d raddr hs%0d", vi, hs), 64'(raddr), 64'(r));
        end else begin
          check($sformatf("v%0d extra chunk", vi), 64'(hs), 64'(total));
        end
        hs++;
      end
      held_v    = strm.out_valid && !strm.out_ready;
      held_d    = strm.out_data;
      held_sol  = strm.out_sol;
      held_last = strm.out_last;
      if (done) begin
        done_cyc = c;
        check($sformatf("v%0d valid low at done", vi), 64'(strm.out_valid), 64'(0));
        check($sformatf("v%0d busy at done", vi), 64'(busy), 64'(1));
      end
      @(posedge clk); #1;
    end
    check($sformatf("v%0d done seen in budget", vi), 64'(done_cyc >= 0), 64'(1));
    check($sformatf("v%0d handshakes", vi), 64'(hs), 64'(total));
    check($sformatf("v%0d first valid cycle", vi), 64'(first_valid), 64'(3));
    if (v.mode == 0)
      check($sformatf("v%0d done cycle", vi), 64'(done_cyc), 64'(18 * v.n_rows + 1));
    @(negedge clk);
    check($sformatf("v%0d done one cycle", vi), 64'(done), 64'(0));
    check($sformatf("v%0d busy idle", vi), 64'(busy), 64'(0));
    check($sformatf("v%0d valid idle", vi), 64'(strm.out_valid), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " busy"},  64'(busy), 64'(0));
    check({tag, " done"},  64'(done), 64'(0));
    check({tag, " valid"}, 64'(strm.out_valid), 64'(0));
    check({tag, " sol"},   64'(strm.out_sol), 64'(0));
    check({tag, " last"},  64'(strm.out_last), 64'(0));
    check({tag, " data"},  64'(strm.out_data), 64'(0));
    check({tag, " raddr"}, 64'(raddr), 64'(0));
  endtask

  initial begin
    int done_seen, r;
    vec_t fresh;
`ifdef IMG_RD_VFLIP_EN
    vecs[0] = '{first: 5,   last: 5,   mode: 0, n_rows: 1,   busy_start: 0};
    vecs[1] = '{first: 1,   last: 510, mode: 0, n_rows: 4,   busy_start: 0};
    vecs[2] = '{first: 511, last: 0,   mode: 0, n_rows: 512, busy_start: 0};
    vecs[3] = '{first: 103, last: 100, mode: 1, n_rows: 4,   busy_start: 0};
    vecs[4] = '{first: 7,   last: 7,   mode: 1, n_rows: 1,   busy_start: 0};
    vecs[5] = '{first: 0,   last: 511, mode: 0, n_rows: 2,   busy_start: 0};
    vecs[6] = '{first: 22,  last: 20,  mode: 0, n_rows: 3,   busy_start: 1};
`else
    vecs[0] = '{first: 5,   last: 5,   mode: 0, n_rows: 1,   busy_start: 0};
    vecs[1] = '{first: 510, last: 1,   mode: 0, n_rows: 4,   busy_start: 0};
    vecs[2] = '{first: 0,   last: 511, mode: 0, n_rows: 512, busy_start: 0};
    vecs[3] = '{first: 100, last: 103, mode: 1, n_rows: 4,   busy_start: 0};
    vecs[4] = '{first: 7,   last: 7,   mode: 1, n_rows: 1,   busy_start: 0};
    vecs[5] = '{first: 511, last: 0,   mode: 0, n_rows: 2,   busy_start: 0};
    vecs[6] = '{first: 20,  last: 22,  mode: 0, n_rows: 3,   busy_start: 1};
`endif
    for (int rr = 0; rr < ROWS; rr++)
      for (int kk = 0; kk < CHUNKS; kk++)
        mem[rr][kk*OUT_W +: OUT_W] = pat(rr, kk);
    strm.out_ready = 1'b0;

    // Reset values, both during and just after reset.
    #2;
    check_zero_outputs("in reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("after reset");
    @(posedge clk); #1;

    for (int vi = 0; vi < 7; vi++) run_frame(vi, vecs[vi]);

    // Reset at chunk 7 of row 2 of a 6-row frame (cycle 3 + 2*18 + 7 = 46).
    start = 1'b1;
    strm.out_ready = 1'b1;
`ifdef IMG_RD_VFLIP_EN
    row_first = 9'd45; row_last = 9'd40;
`else
    row_first = 9'd40; row_last = 9'd45;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    r = exp_row(int'(row_first), 2);
    repeat (45) @(posedge clk);
    @(negedge clk);
    check("abort pre valid", 64'(strm.out_valid), 64'(1));
    check("abort pre data", 64'(strm.out_data), 64'(pat(r, 7)));
    rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy || strm.out_valid) done_seen++;
    end
    check("abort stays idle", 64'(done_seen), 64'(0));
    @(posedge clk); #1;

    fresh = '{first: 40, last: 41, mode: 1, n_rows: 2, busy_start: 0};
`ifdef IMG_RD_VFLIP_EN
    fresh.first = 41; fresh.last = 40;
`endif
    run_frame(7, fresh);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/img_buf_rd_stream.md
# img_buf_rd_stream

Row-streaming reader for the 512x512 1-bit-per-pixel image buffer. On a start command it fetches a contiguous range of rows through the buffer's synchronous read port. Each 512-bit row is serialized into 32-bit chunks on a valid/ready stream toward the coprocessor datapath or the VGA/host path. It is the read-side counterpart of the module that fills the buffer through its write port.

## Interface
- ROWS, 512: rows in buffer
- ROW_W, 512: bits per row (equal to the buffer word width)
- OUT_W, 32: stream chunk width; ROW_W must be a multiple of OUT_W; CHUNKS = ROW_W/OUT_W (16)
- ADDR_W, 9: row address width, log2(ROWS)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command strobe; sampled only in IDLE
- row_first  in  ADDR_W  first row to read; latched on accepted start
- row_last  in  ADDR_W  last row to read; latched on accepted start
- busy  out  1  high from the cycle after an accepted start through DONE
- done  out  1  one-cycle pulse at end of frame
- raddr  out  ADDR_W  buffer read address; registered and driven from cur_row
- rdata  in  ROW_W  buffer read data; valid one clock after raddr
- out_data  out  OUT_W  current chunk
- out_valid  out  1  chunk valid
- out_ready  in  1  downstream accept
- out_sol  out  1  qualifies out_data as chunk 0 of a row
- out_last  out  1  qualifies out_data as the final chunk of the final row

## Operation
- States: IDLE, FETCH, LOAD, STREAM, DONE.
- IDLE: when start=1:
  - latch row_first and row_last
  - set cur_row = row_first and rows_left = ((row_last - row_first) mod ROWS)
  - go to FETCH
- FETCH: raddr = cur_row. The buffer registers mem[cur_row] at the closing edge. Go to LOAD.
- LOAD: capture rdata into row_reg, set chunk_idx = 0, go to STREAM.
- STREAM:
  - out_valid=1; out_data = row_reg[chunk_idx*OUT_W +: OUT_W], so chunk 0 is the LSBs.
  - out_sol = (chunk_idx==0); out_last = (chunk_idx==CHUNKS-1 && rows_left==0).
  - On out_valid && out_ready, chunk_idx increments.
  - On the handshake of chunk CHUNKS-1: if rows_left==0, go to DONE. Otherwise decrement rows_left, step cur_row, and go to FETCH.
- DONE: done=1 for one cycle, then IDLE. busy deasserts when IDLE is entered.
- Row stepping: cur_row steps +1 mod ROWS. It wraps 511→0, so row_last < row_first reads a wrapped range. row_first == row_last reads exactly one row.
- Row count per frame = ((row_last - row_first) mod ROWS) + 1, with a range of 1..512. row_last = row_first-1 reads all 512 rows.
- start is ignored in every state other than IDLE. No queuing.
- row_first and row_last may change after start without effect.
- The writer must not modify rows within the active range while busy. The reader does not check for this.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_sol=0, out_last=0, out_data=0, raddr=0. State=IDLE, all counters 0.
- An asserted rst_n mid-frame aborts immediately. No done pulse is produced; the next frame requires a new start.
- Start accepted at cycle 0. FETCH is cycle 1, LOAD is cycle 2, and the first out_valid is at cycle 3.
- With out_ready held high:
  - one chunk per cycle
  - 2-cycle bubble (FETCH, LOAD) between rows
  - a row costs CHUNKS+2 = 18 cycles
  - an N-row frame takes 18N cycles from start to the DONE cycle
- Backpressure: while out_valid && !out_ready, out_data, out_sol and out_last are held stable. out_valid never drops without a handshake.
- out_valid deasserts in the cycle after the final handshake. done rises in that same cycle.

## Configuration
- IMG_RD_VFLIP_EN defined: cur_row steps -1 mod ROWS (0→511 wrap), giving a vertical flip. Row count = ((row_first - row_last) mod ROWS) + 1.
- IMG_RD_VFLIP_EN not defined: ascending traversal as described in Operation. The decrement logic is absent.

## Test plan
- Reset values and single row: reset, then start with first=last=5 and mem[5] = {16{32'hA5A5_0000 + k}} per chunk k. Required response:
  - first out_valid at cycle 3
  - 16 chunks in LSB-first order
  - out_sol on chunk 0; out_last on chunk 15
  - done pulse one cycle later; 18 cycles total
- Wrap range: first=510, last=1. Required response: rows streamed 510, 511, 0, 1; out_last only on chunk 15 of row 1; done after 72 cycles.
- Full frame: first=0, last=511. Required response: 512×16 = 8192 handshakes; raddr sequence 0..511.
- Backpressure: toggle out_ready in a random 50% pattern. Required response: out_data, out_sol and out_last held stable while stalled; no chunk lost or duplicated; data matches the memory image.
- Start while busy and reset mid-frame: pulse start during STREAM and confirm it is ignored. Assert rst_n at chunk 7 of row 2. Required response:
  - all outputs 0 immediately
  - no done pulse
  - a fresh start reads correctly
- VFLIP build: with IMG_RD_VFLIP_EN defined, first=1 and last=510. Required response: rows 1, 0, 511, 510 in that order.
